// File: rtl/register_bus_reader_pkg.sv
// Shared definitions for the register bus read controller and the registers attached to the bus.
package register_bus_reader_pkg;

  // Defaults shared with the register bank.
  localparam int unsigned DefNrOfBits = 32;
  localparam int unsigned DefNrOfRegs = 4;
  localparam int unsigned DefAddrBits = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TURN    = 3'd1;
  localparam logic [2:0] ST_SELECT  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  typedef enum logic [2:0] {
    StIdle    = ST_IDLE,
    StTurn    = ST_TURN,
    StSelect  = ST_SELECT,
    StCapture = ST_CAPTURE,
    StResp    = ST_RESP
  } state_e;

  localparam logic [DefNrOfRegs-1:0] CS_IDLE = '1;

  // The counter runs SettleCycles-1 down to 0, so SELECT lasts SettleCycles cycles.
  function automatic logic [3:0] settle_load(input int unsigned settle);
    return 4'(settle - 1);
  endfunction

endpackage

// File: rtl/register_bus_reader_if.sv
// Request, shared bus and response signals of the register bus reader.
interface register_bus_reader_if
  import register_bus_reader_pkg::*;
#(
  parameter int unsigned NrOfBits = DefNrOfBits,
  parameter int unsigned NrOfRegs = DefNrOfRegs,
  parameter int unsigned AddrBits = DefAddrBits
);

  logic                req_valid;
  logic [AddrBits-1:0] req_addr;
  logic                req_ready;
  logic [NrOfBits-1:0] bus_in;
  logic [NrOfRegs-1:0] cs_n;
  logic                rsp_valid;
  logic [NrOfBits-1:0] rsp_data;
  logic                rsp_err;
  logic                rsp_ready;

  modport master (
    input  req_valid,
    input  req_addr,
    input  bus_in,
    input  rsp_ready,
    output req_ready,
    output cs_n,
    output rsp_valid,
    output rsp_data,
    output rsp_err
  );

  modport slave (
    output req_valid,
    output req_addr,
    output bus_in,
    output rsp_ready,
    input  req_ready,
    input  cs_n,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
  );

endinterface

// File: rtl/register_bus_reader_cs_n_decoder.sv
// One-hot-low chip-select decoder; all ones when disabled or when the address has no register.
module register_bus_reader_cs_n_decoder
  import register_bus_reader_pkg::*;
#(
  parameter int unsigned NrOfRegs = DefNrOfRegs,
  parameter int unsigned AddrBits = DefAddrBits
) (
  input  logic                en_i,
  input  logic [AddrBits-1:0] addr_i,
  output logic [NrOfRegs-1:0] cs_n_o
);

  always_comb begin
    cs_n_o = '1;
    for (int unsigned i = 0; i < NrOfRegs; i++) begin
      if (en_i && (addr_i == AddrBits'(i))) begin
        cs_n_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/register_bus_reader.sv
// Read controller for the shared tri-state register bus: turnaround, select, settle, capture,
// respond.
module register_bus_reader
  import register_bus_reader_pkg::*;
#(
  parameter int unsigned NrOfBits     = DefNrOfBits,
  parameter int unsigned NrOfRegs     = DefNrOfRegs,
  parameter int unsigned AddrBits     = DefAddrBits,
  parameter int unsigned SettleCycles = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tick_i,
  register_bus_reader_if.master  bus_io
);

  localparam logic [3:0] SettleLoad = settle_load(SettleCycles);

  state_e              state_q, state_d;
  logic [AddrBits-1:0] addr_q, addr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [NrOfRegs-1:0] cs_n_q, cs_n_d;
  logic [NrOfBits-1:0] data_q, data_d;
  logic                err_q, err_d;
  logic                addr_ok;
  logic                cs_en_d;

  assign addr_ok = 32'(bus_io.req_addr) < NrOfRegs;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    if (tick_i) begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.req_valid) begin
            addr_d = bus_io.req_addr;
            if (addr_ok) begin
              state_d = StTurn;
            end else begin
              state_d = StResp;
              data_d  = '0;
              err_d   = 1'b1;
            end
          end
        end
        StTurn: begin
          state_d = StSelect;
          cnt_d   = SettleLoad;
        end
        StSelect: begin
          if (cnt_q == 4'd0) begin
            state_d = StCapture;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StCapture: begin
          data_d  = bus_io.bus_in;
          err_d   = 1'b0;
          state_d = StResp;
        end
        StResp: begin
          if (bus_io.rsp_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Chip-selects are decoded from the next state and registered so the pins never glitch.
  assign cs_en_d = (state_d == StSelect) || (state_d == StCapture);

  register_bus_reader_cs_n_decoder #(
    .NrOfRegs (NrOfRegs),
    .AddrBits (AddrBits)
  ) u_cs_n_decoder (
    .en_i   (cs_en_d),
    .addr_i (addr_d),
    .cs_n_o (cs_n_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      cs_n_q  <= '1;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.req_ready = (state_q == StIdle) && !rst_i;
  assign bus_io.cs_n      = cs_n_q;
  assign bus_io.rsp_valid = (state_q == StResp);
  assign bus_io.rsp_data  = data_q;
  assign bus_io.rsp_err   = err_q;

endmodule
